// File: rtl/tetris_move_ctrl.sv
// Piece-motion controller: button/gravity events -> checked move proposals -> committed piece state.
// Define HARD_DROP_EN to add the btn_drop input and the hard-drop sequencer.

module tetris_move_rep #(
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4,
  parameter bit REPEAT_EN    = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_q,
  input  logic btn_prev,
  output logic ev
);
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [CW-1:0] cnt;
  logic          rep;
  logic          fire;

  // cnt equals the hold cycle index until the first repeat, then the cycles since the last one
  always_comb begin
    fire = 1'b0;
    if (REPEAT_EN && btn_q)
      fire = rep ? (cnt == CW'(REPEAT_RATE)) : (cnt == CW'(REPEAT_DELAY));
  end

  assign ev = (btn_q & ~btn_prev) | fire;

  always_ff @(posedge clk) begin
    if (!rst_n || !btn_q || !REPEAT_EN) begin
      cnt <= '0;
      rep <= 1'b0;
    end else if (fire) begin
      cnt <= CW'(1);
      rep <= 1'b1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

module tetris_move_ctrl #(
  parameter int X_W          = 5,
  parameter int Y_W          = 5,
  parameter int ROT_W        = 2,
  parameter int X_MAX        = 9,
  parameter int Y_MAX        = 19,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4,
  parameter int DROP_PERIOD  = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spawn,
  input  logic [X_W-1:0]   spawn_x,
  input  logic [Y_W-1:0]   spawn_y,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_down,
  input  logic             btn_rot,
`ifdef HARD_DROP_EN
  input  logic             btn_drop,
`endif
  output logic             chk_req,
  output logic [X_W-1:0]   chk_x,
  output logic [Y_W-1:0]   chk_y,
  output logic [ROT_W-1:0] chk_rot,
  input  logic             chk_ack,
  input  logic             chk_ok,
  output logic [X_W-1:0]   pos_x,
  output logic [Y_W-1:0]   pos_y,
  output logic [ROT_W-1:0] rot,
  output logic             lock,
  output logic             busy
);
  localparam int NB = 4;
  localparam int GW = (DROP_PERIOD > 2) ? $clog2(DROP_PERIOD) : 1;

  typedef enum logic {IDLE, REQ} state_t;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [ROT_W-1:0] r;
  } piece_t;

  typedef struct packed {
`ifdef HARD_DROP_EN
    logic drop;
`endif
    logic grav;
    logic rot;
    logic left;
    logic right;
    logic down;
  } pend_t;

  state_t        state, state_n;
  pend_t         pend, pend_n;
  piece_t        cur, cur_n, prop, prop_n;
  logic          mv_down, mv_down_n;
  logic          frozen, frozen_n;
  logic          lock_q, lock_n;
  logic [GW-1:0] grav_cnt, grav_cnt_n;
  logic          grav_ev, ev_en, take_down;

  // bit order: 0 left, 1 right, 2 down, 3 rot
  logic [NB-1:0] btn_raw, btn_q, btn_prev, btn_ev;
  assign btn_raw = {btn_rot, btn_down, btn_right, btn_left};

  for (genvar i = 0; i < NB; i++) begin : g_btn
    tetris_move_rep #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE),
      .REPEAT_EN    (i != 3)
    ) u_rep (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_q    (btn_q[i]),
      .btn_prev (btn_prev[i]),
      .ev       (btn_ev[i])
    );
  end

`ifdef HARD_DROP_EN
  logic drop_q, drop_prev, drop_ev, drop_act, drop_act_n;
  assign drop_ev = drop_q & ~drop_prev;
`endif

  always_comb begin
    state_n    = state;
    pend_n     = pend;
    cur_n      = cur;
    prop_n     = prop;
    mv_down_n  = mv_down;
    frozen_n   = frozen;
    lock_n     = 1'b0;
    grav_cnt_n = grav_cnt;
    grav_ev    = 1'b0;
    take_down  = 1'b0;
    ev_en      = !frozen;
`ifdef HARD_DROP_EN
    drop_act_n = drop_act;
    ev_en      = !frozen && !drop_act;
`endif

    if (!frozen) begin
      if (grav_cnt == GW'(DROP_PERIOD - 1)) begin
        grav_cnt_n = '0;
        grav_ev    = 1'b1;
      end else begin
        grav_cnt_n = grav_cnt + GW'(1);
      end
    end

    unique case (state)
      IDLE: if (!frozen) begin
`ifdef HARD_DROP_EN
        if (drop_act) begin
          take_down = 1'b1;
        end else if (pend.drop) begin
          pend_n.drop = 1'b0;
          drop_act_n  = 1'b1;
          take_down   = 1'b1;
        end else
`endif
        if (pend.grav) begin
          pend_n.grav = 1'b0;
          take_down   = 1'b1;
        end else if (pend.rot) begin
          pend_n.rot = 1'b0;
          prop_n     = cur;
          prop_n.r   = cur.r + ROT_W'(1);
          mv_down_n  = 1'b0;
          state_n    = REQ;
        end else if (pend.left) begin
          pend_n.left = 1'b0;
          if (cur.x != '0) begin
            prop_n    = cur;
            prop_n.x  = cur.x - X_W'(1);
            mv_down_n = 1'b0;
            state_n   = REQ;
          end
        end else if (pend.right) begin
          pend_n.right = 1'b0;
          if (cur.x != X_W'(X_MAX)) begin
            prop_n    = cur;
            prop_n.x  = cur.x + X_W'(1);
            mv_down_n = 1'b0;
            state_n   = REQ;
          end
        end else if (pend.down) begin
          pend_n.down = 1'b0;
          take_down   = 1'b1;
        end

        // a downward move from the bottom row lands without consulting the checker
        if (take_down) begin
          if (cur.y == Y_W'(Y_MAX)) begin
            lock_n = 1'b1;
          end else begin
            prop_n    = cur;
            prop_n.y  = cur.y + Y_W'(1);
            mv_down_n = 1'b1;
            state_n   = REQ;
          end
        end
      end
      REQ: if (chk_ack) begin
        state_n = IDLE;
        if (chk_ok)       cur_n  = prop;
        else if (mv_down) lock_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    if (ev_en) begin
      pend_n.left  = pend_n.left  | btn_ev[0];
      pend_n.right = pend_n.right | btn_ev[1];
      pend_n.down  = pend_n.down  | btn_ev[2];
      pend_n.rot   = pend_n.rot   | btn_ev[3];
`ifdef HARD_DROP_EN
      pend_n.drop  = pend_n.drop  | drop_ev;
`endif
    end
    if (grav_ev) pend_n.grav = 1'b1;
    if (pend_n.left && pend_n.right) begin
      pend_n.left  = 1'b0;
      pend_n.right = 1'b0;
    end

    if (lock_n) begin
      frozen_n = 1'b1;
      pend_n   = '0;
`ifdef HARD_DROP_EN
      drop_act_n = 1'b0;
`endif
    end

    // spawn overrides everything, including a lock raised in the same cycle
    if (spawn) begin
      state_n    = IDLE;
      cur_n.x    = spawn_x;
      cur_n.y    = spawn_y;
      cur_n.r    = '0;
      pend_n     = '0;
      frozen_n   = 1'b0;
      lock_n     = 1'b0;
      grav_cnt_n = '0;
`ifdef HARD_DROP_EN
      drop_act_n = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      pend     <= '0;
      cur      <= '0;
      prop     <= '0;
      mv_down  <= 1'b0;
      frozen   <= 1'b1;
      lock_q   <= 1'b0;
      grav_cnt <= '0;
      btn_q    <= '0;
      btn_prev <= '0;
    end else begin
      state    <= state_n;
      pend     <= pend_n;
      cur      <= cur_n;
      prop     <= prop_n;
      mv_down  <= mv_down_n;
      frozen   <= frozen_n;
      lock_q   <= lock_n;
      grav_cnt <= grav_cnt_n;
      btn_q    <= btn_raw;
      btn_prev <= btn_q;
    end
  end

`ifdef HARD_DROP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_q    <= 1'b0;
      drop_prev <= 1'b0;
      drop_act  <= 1'b0;
    end else begin
      drop_q    <= btn_drop;
      drop_prev <= drop_q;
      drop_act  <= drop_act_n;
    end
  end
`endif

  assign chk_req = (state == REQ);
  assign busy    = (state != IDLE);
  assign chk_x   = prop.x;
  assign chk_y   = prop.y;
  assign chk_rot = prop.r;
  assign pos_x   = cur.x;
  assign pos_y   = cur.y;
  assign rot     = cur.r;
  assign lock    = lock_q;
endmodule

// File: tb/tb_tetris_move_ctrl.sv
// Directed bench for tetris_move_ctrl: vector table for single moves plus sequences for repeat,
// bounds, gravity lock, spawn abort and mid-operation reset.

module tb_tetris_move_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spawn = 1'b0;
  logic [4:0] spawn_x = '0, spawn_y = '0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_rot = 1'b0;
`ifdef HARD_DROP_EN
  logic       btn_drop = 1'b0;
`endif
  logic       chk_req, lock, busy, chk_ack, chk_ok;
  logic [4:0] chk_x, chk_y, pos_x, pos_y;
  logic [1:0] chk_rot, rot;

  // checker model: auto-ack in the request cycle, legal while the proposed row is within y_lim
  logic       ack_en = 1'b0, ack_man = 1'b0;
  logic [4:0] y_lim = 5'd31;
  assign chk_ack = (ack_en & chk_req) | ack_man;
  assign chk_ok  = (chk_y <= y_lim);

  int n_chk = 0, n_fail = 0;

  tetris_move_ctrl #(
    .X_W(5), .Y_W(5), .ROT_W(2), .X_MAX(9), .Y_MAX(19),
    .REPEAT_DELAY(16), .REPEAT_RATE(4), .DROP_PERIOD(48)
  ) dut (
    .clk(clk), .rst_n(rst_n), .spawn(spawn), .spawn_x(spawn_x), .spawn_y(spawn_y),
    .btn_left(btn_left), .btn_right(btn_right), .btn_down(btn_down), .btn_rot(btn_rot),
`ifdef HARD_DROP_EN
    .btn_drop(btn_drop),
`endif
    .chk_req(chk_req), .chk_x(chk_x), .chk_y(chk_y), .chk_rot(chk_rot),
    .chk_ack(chk_ack), .chk_ok(chk_ok),
    .pos_x(pos_x), .pos_y(pos_y), .rot(rot), .lock(lock), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sp;
    logic [4:0] sx, sy;
    logic       l, r, d, ro;
    logic [4:0] px, py;
    logic [1:0] pr;
    logic       req;
    logic [4:0] cx, cy;
    logic [1:0] cr;
  } vec_t;

  localparam int NV = 19;
  vec_t tv[NV];

  function automatic vec_t mk(int sp, int sx, int sy, int l, int r, int d, int ro,
                              int px, int py, int pr, int req, int cx, int cy, int cr);
    vec_t v;
    v.sp = 1'(sp); v.sx = 5'(sx); v.sy = 5'(sy);
    v.l = 1'(l); v.r = 1'(r); v.d = 1'(d); v.ro = 1'(ro);
    v.px = 5'(px); v.py = 5'(py); v.pr = 2'(pr); v.req = 1'(req);
    v.cx = 5'(cx); v.cy = 5'(cy); v.cr = 2'(cr);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_spawn(input int x, input int y);
    spawn = 1'b1; spawn_x = 5'(x); spawn_y = 5'(y);
    step();
    spawn = 1'b0;
  endtask

  initial begin
    int req_k[$];
    int exp_k[5];
    int req_cnt, lock_cnt, lock_k;

    // reset state and no motion before the first spawn
    step(); step();
    chk("rst chk_req", 32'(chk_req), 0);
    chk("rst pos_x",   32'(pos_x), 0);
    chk("rst pos_y",   32'(pos_y), 0);
    chk("rst rot",     32'(rot), 0);
    chk("rst lock",    32'(lock), 0);
    chk("rst busy",    32'(busy), 0);
    chk("rst chk_x",   32'(chk_x), 0);
    rst_n = 1'b1;
    ack_en = 1'b1;
    req_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      btn_left = (k < 3);
      step();
      if (chk_req) req_cnt++;
    end
    chk("frozen before spawn req count", 32'(req_cnt), 0);

    // spawn, left with same-cycle ack, rotate, down, left+right cancel
    tv[0]  = mk(1,4,0, 0,0,0,0, 4,0,0, 0, 0,0,0);
    tv[1]  = mk(0,0,0, 1,0,0,0, 4,0,0, 0, 0,0,0);
    tv[2]  = mk(0,0,0, 1,0,0,0, 4,0,0, 0, 0,0,0);
    tv[3]  = mk(0,0,0, 1,0,0,0, 4,0,0, 1, 3,0,0);
    tv[4]  = mk(0,0,0, 0,0,0,0, 3,0,0, 0, 0,0,0);
    tv[5]  = mk(0,0,0, 0,0,0,0, 3,0,0, 0, 0,0,0);
    tv[6]  = mk(0,0,0, 0,0,0,0, 3,0,0, 0, 0,0,0);
    tv[7]  = mk(0,0,0, 0,0,0,1, 3,0,0, 0, 0,0,0);
    tv[8]  = mk(0,0,0, 0,0,0,1, 3,0,0, 0, 0,0,0);
    tv[9]  = mk(0,0,0, 0,0,0,0, 3,0,0, 1, 3,0,1);
    tv[10] = mk(0,0,0, 0,0,0,0, 3,0,1, 0, 0,0,0);
    tv[11] = mk(0,0,0, 0,0,1,0, 3,0,1, 0, 0,0,0);
    tv[12] = mk(0,0,0, 0,0,0,0, 3,0,1, 0, 0,0,0);
    tv[13] = mk(0,0,0, 0,0,0,0, 3,0,1, 1, 3,1,1);
    tv[14] = mk(0,0,0, 0,0,0,0, 3,1,1, 0, 0,0,0);
    tv[15] = mk(0,0,0, 1,1,0,0, 3,1,1, 0, 0,0,0);
    tv[16] = mk(0,0,0, 0,0,0,0, 3,1,1, 0, 0,0,0);
    tv[17] = mk(0,0,0, 0,0,0,0, 3,1,1, 0, 0,0,0);
    tv[18] = mk(0,0,0, 0,0,0,0, 3,1,1, 0, 0,0,0);

    for (int i = 0; i < NV; i++) begin
      spawn = tv[i].sp; spawn_x = tv[i].sx; spawn_y = tv[i].sy;
      btn_left = tv[i].l; btn_right = tv[i].r; btn_down = tv[i].d; btn_rot = tv[i].ro;
      step();
      chk($sformatf("v%0d pos_x", i),   32'(pos_x),   32'(tv[i].px));
      chk($sformatf("v%0d pos_y", i),   32'(pos_y),   32'(tv[i].py));
      chk($sformatf("v%0d rot", i),     32'(rot),     32'(tv[i].pr));
      chk($sformatf("v%0d chk_req", i), 32'(chk_req), 32'(tv[i].req));
      chk($sformatf("v%0d lock", i),    32'(lock),    0);
      if (tv[i].req) begin
        chk($sformatf("v%0d chk_x", i),   32'(chk_x),   32'(tv[i].cx));
        chk($sformatf("v%0d chk_y", i),   32'(chk_y),   32'(tv[i].cy));
        chk($sformatf("v%0d chk_rot", i), 32'(chk_rot), 32'(tv[i].cr));
      end
    end

    // rotation wraps 1 -> 2 -> 3 -> 0
    for (int p = 0; p < 3; p++) begin
      btn_rot = 1'b1;
      step();
      btn_rot = 1'b0;
      repeat (4) step();
      chk($sformatf("rot wrap %0d", p), 32'(rot), 32'((p + 2) % 4));
    end

    // right held 30 cycles: events at hold 0,16,20,24,28, capped at X_MAX
    do_spawn(4, 0);
    exp_k = '{2, 18, 22, 26, 30};
    for (int k = 0; k < 40; k++) begin
      btn_right = (k < 30);
      step();
      if (chk_req) req_k.push_back(k);
    end
    chk("repeat req count", 32'(req_k.size()), 5);
    for (int j = 0; j < 5; j++)
      chk($sformatf("repeat req %0d cycle", j),
          32'((j < req_k.size()) ? req_k[j] : -1), 32'(exp_k[j]));
    chk("repeat final pos_x", 32'(pos_x), 9);

    // left at column 0 is dropped without a request
    do_spawn(0, 2);
    req_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      btn_left = (k < 3);
      step();
      if (chk_req) req_cnt++;
    end
    chk("left at x=0 req count", 32'(req_cnt), 0);
    chk("left at x=0 pos_x", 32'(pos_x), 0);

    // down at the bottom row locks directly
    do_spawn(5, 19);
    req_cnt = 0; lock_cnt = 0; lock_k = -1;
    for (int k = 0; k < 6; k++) begin
      btn_down = (k == 0);
      step();
      if (chk_req) req_cnt++;
      if (lock) begin lock_cnt++; if (lock_k < 0) lock_k = k; end
    end
    chk("bottom down req count", 32'(req_cnt), 0);
    chk("bottom down lock count", 32'(lock_cnt), 1);
    chk("bottom down lock cycle", 32'(lock_k), 2);
    chk("bottom down pos_y", 32'(pos_y), 19);

    // gravity refused at row 5: one-cycle lock, then buttons ignored
    y_lim = 5'd5;
    do_spawn(4, 5);
    lock_cnt = 0; lock_k = -1;
    for (int k = 1; k <= 70; k++) begin
      step();
      if (lock) begin lock_cnt++; if (lock_k < 0) lock_k = k; end
    end
    chk("gravity lock count", 32'(lock_cnt), 1);
    chk("gravity lock cycle", 32'(lock_k), 50);
    chk("gravity lock pos_y", 32'(pos_y), 5);
    req_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      btn_left = (k < 3);
      step();
      if (chk_req) req_cnt++;
    end
    chk("after lock req count", 32'(req_cnt), 0);
    chk("after lock pos_x", 32'(pos_x), 4);
    y_lim = 5'd31;

    // spawn aborts an outstanding request; a late ack changes nothing
    ack_en = 1'b0;
    do_spawn(4, 0);
    btn_left = 1'b1; step(); step();
    btn_left = 1'b0; step();
    chk("abort req raised", 32'(chk_req), 1);
    chk("abort chk_x", 32'(chk_x), 3);
    step(); step();
    chk("abort req held", 32'(chk_req), 1);
    chk("abort chk_x held", 32'(chk_x), 3);
    do_spawn(2, 1);
    chk("abort req dropped", 32'(chk_req), 0);
    chk("abort pos_x", 32'(pos_x), 2);
    chk("abort pos_y", 32'(pos_y), 1);
    ack_man = 1'b1;
    step();
    ack_man = 1'b0;
    chk("late ack pos_x", 32'(pos_x), 2);
    chk("late ack pos_y", 32'(pos_y), 1);
    chk("late ack req", 32'(chk_req), 0);

    // reset in the middle of a request
    btn_right = 1'b1; step();
    btn_right = 1'b0; step(); step();
    chk("mid reset req before", 32'(chk_req), 1);
    rst_n = 1'b0; step();
    chk("mid reset chk_req", 32'(chk_req), 0);
    chk("mid reset pos_x", 32'(pos_x), 0);
    chk("mid reset pos_y", 32'(pos_y), 0);
    chk("mid reset busy", 32'(busy), 0);
    rst_n = 1'b1;
    ack_en = 1'b1;
    req_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      btn_right = (k < 2);
      step();
      if (chk_req) req_cnt++;
    end
    chk("mid reset frozen req count", 32'(req_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
